// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line-rate constants and
// a parity helper reused by the transmitter, the receiver and the bench.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int CLK_FREQ_HZ      = 50_000_000;
    localparam int BAUD_RATE        = 115_200;
    localparam int BAUD_DIV_DEFAULT = CLK_FREQ_HZ / BAUD_RATE;

    // Word is zero-extended to 9 bits, so any DATA_WIDTH up to 9 fits.
    function automatic logic parity_of(input logic [8:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..BAUD_DIV-1 while run is high, ticks on the
// last count of each bit and sits at 0 whenever run is low.
module uart_baud_tick #(
    parameter int BAUD_DIV = 434,
    localparam int CW = $clog2(BAUD_DIV)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    output logic          tick,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_LAST);
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!run || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: one accepted start pulse sends start bit, data LSB
// first, optional parity and 1-2 stop bits on a registered, idle-high line.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_DIV   = 434,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam int IW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    if (BAUD_DIV < 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_params
        $error("uart_tx_frame: illegal parameter combination");
    end

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [IW-1:0]         bit_idx_q, bit_idx_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic          baud_tick;
    logic [CW-1:0] baud_cnt;
    logic          bit_end;

    uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk   (clk),
        .reset (reset),
        .run   (state_q != IDLE),
        .tick  (baud_tick),
        .cnt   (baud_cnt)
    );

    assign bit_end = baud_tick && (baud_cnt == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        done_d     = 1'b0;
        tx_d       = 1'b1;

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    state_d    = START;
                    shreg_d    = tx_data;
                    par_d      = parity_of(9'(tx_data), 1'(PARITY_ODD));
                    bit_idx_d  = '0;
                    stop_cnt_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == BIT_LAST) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        stop_cnt_d = 1'b0;
                        state_d    = IDLE;
                        done_d     = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is computed from the next state so tx stays a pure flop.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four builds (plain, even parity, odd parity,
// BAUD_DIV=5 with two stop bits) checked cycle by cycle against a frame queue.
module tb_uart_tx_frame;

    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
    } exp_t;

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic       par;
        int         len;
    } vec_t;

    localparam int ND = 4;
    int BD [ND] = '{4, 4, 4, 5};
    int PEN[ND] = '{0, 1, 1, 0};
    int STB[ND] = '{1, 1, 1, 2};

    logic          clk = 1'b0;
    logic          reset;
    logic [ND-1:0] start_w;
    logic [7:0]    tx_data;
    logic [ND-1:0] tx_w, busy_w, done_w;

    exp_t exp_q[$];
    int   cur;
    int   errors = 0;
    int   checks = 0;
    int   run_len = 0;
    int   last_len = -1;
    vec_t vecs[8];

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_WIDTH(8), .BAUD_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_plain (
        .clk(clk), .reset(reset), .tx_start(start_w[0]), .tx_data(tx_data),
        .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
    uart_tx_frame #(.DATA_WIDTH(8), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
        .clk(clk), .reset(reset), .tx_start(start_w[1]), .tx_data(tx_data),
        .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
    uart_tx_frame #(.DATA_WIDTH(8), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .reset(reset), .tx_start(start_w[2]), .tx_data(tx_data),
        .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
    uart_tx_frame #(.DATA_WIDTH(8), .BAUD_DIV(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .reset(reset), .tx_start(start_w[3]), .tx_data(tx_data),
        .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every instance other than the active one must stay idle; the active one
    // follows the queued frame, then idles once the queue drains.
    always @(negedge clk) begin
        for (int i = 0; i < ND; i++) begin
            exp_t e;
            exp_t a;
            e = '{tx: 1'b1, busy: 1'b0, done: 1'b0};
            if (!reset && i == cur && exp_q.size() > 0) e = exp_q.pop_front();
            a = '{tx: tx_w[i], busy: busy_w[i], done: done_w[i]};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL line dut%0d at %0t: tx/busy/done got %b expected %b", i, $time, a, e);
            end
        end
        if (busy_w[cur]) run_len++;
        else if (run_len != 0) begin
            last_len = run_len;
            run_len  = 0;
        end
    end

    task automatic push_frame(input int d, input logic [7:0] data, input logic par);
        for (int c = 0; c < BD[d]; c++) exp_q.push_back('{1'b0, 1'b1, 1'b0});
        for (int b = 0; b < 8; b++)
            for (int c = 0; c < BD[d]; c++) exp_q.push_back('{data[b], 1'b1, 1'b0});
        if (PEN[d] != 0)
            for (int c = 0; c < BD[d]; c++) exp_q.push_back('{par, 1'b1, 1'b0});
        for (int c = 0; c < STB[d] * BD[d]; c++) exp_q.push_back('{1'b1, 1'b1, 1'b0});
        exp_q.push_back('{1'b1, 1'b0, 1'b1});
    endtask

    task automatic send(input int d, input logic [7:0] data, input logic par);
        cur      = d;
        last_len = -1;
        @(posedge clk);
        #1;
        tx_data    = data;
        start_w[d] = 1'b1;
        @(posedge clk);
        push_frame(d, data, par);
        #1;
        start_w = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{dut: 0, data: 8'h55, par: 1'b0, len: 40};
        vecs[1] = '{dut: 1, data: 8'h07, par: 1'b1, len: 44};
        vecs[2] = '{dut: 2, data: 8'h07, par: 1'b0, len: 44};
        vecs[3] = '{dut: 3, data: 8'h00, par: 1'b0, len: 55};
        vecs[4] = '{dut: 1, data: 8'hA5, par: 1'b0, len: 44};
        vecs[5] = '{dut: 2, data: 8'hA5, par: 1'b1, len: 44};
        vecs[6] = '{dut: 0, data: 8'hFF, par: 1'b0, len: 40};
        vecs[7] = '{dut: 3, data: 8'hC3, par: 1'b0, len: 55};

        reset   = 1'b1;
        start_w = '0;
        tx_data = '0;
        cur     = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);

        foreach (vecs[k]) begin
            send(vecs[k].dut, vecs[k].data, vecs[k].par);
            wait_idle();
            chk($sformatf("busy_len_v%0d", k), last_len, vecs[k].len);
        end

        // Re-pulse mid-frame is ignored; start in the done cycle chains directly.
        send(0, 8'hA3, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        tx_data    = 8'hFF;
        start_w[0] = 1'b1;
        @(posedge clk);
        #1;
        start_w = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done_w[0] !== 1'b1 && n < 100);
        chk("done_seen_a3", int'(done_w[0]), 1);
        tx_data    = 8'h3C;
        start_w[0] = 1'b1;
        @(posedge clk);
        push_frame(0, 8'h3C, 1'b0);
        #1;
        start_w = '0;
        wait_idle();
        chk("busy_len_3c", last_len, 40);

        // Reset in the middle of data bit 3 of 8'h81 (a 0 bit).
        send(0, 8'h81, 1'b0);
        repeat (17) @(posedge clk);
        #1;
        chk("tx_low_before_reset", int'(tx_w[0]), 0);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("tx_async_reset", int'(tx_w[0]), 1);
        chk("busy_async_reset", int'(busy_w[0]), 0);
        chk("done_async_reset", int'(done_w[0]), 0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (5) @(posedge clk);
        send(0, 8'h81, 1'b0);
        wait_idle();
        chk("busy_len_after_reset", last_len, 40);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
